vga_ctrl_param: RTL and testbench

VGA_CTRL_PARAM -- requirements
Module: vga_ctrl_param

---
 rtl/vga_ctrl_param.sv | 171 +++++++++++++++++
 tb/tb_vga_ctrl_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_ctrl_param.sv
// vga_ctrl_param: parameterised VGA timing generator with a frame-store fetch
// pipeline. The addresses are registered. Sync, valid and the frame/line
// pulses are delayed 1+FETCH_LAT cycles, so they line up with the colour
// data returned by the frame store.
// Optional feature, enabled by defining VGA_CTRL_PARAM_TESTPAT_EN: adds a
// test_en input that replaces vga_data with eight vertical colour bars.
module vga_ctrl_param #(
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CW        = 12,
    parameter int FETCH_LAT = 1
) (
    input  logic          pclk,
    input  logic          reset,
`ifdef VGA_CTRL_PARAM_TESTPAT_EN
    input  logic          test_en,
`endif
    input  logic [23:0]   vga_data,
    output logic [CW-1:0] h_addr,
    output logic [CW-1:0] v_addr,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          frame_start,
    output logic          line_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DLY     = 1 + FETCH_LAT;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_E = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_E = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_S  = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_ACT_S  = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT_E  = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_E  = CW'(V_SYNC + V_BP + V_ACTIVE);

    // Each pipeline stage carries {hpos (pattern build only), hs, vs, valid, fs, ls}.
    // Sync levels are stored already polarised so the reset value is the idle level.
`ifdef VGA_CTRL_PARAM_TESTPAT_EN
    localparam int SW = 5 + CW;
    localparam logic [SW-1:0] RST_STAGE = {{CW{1'b0}}, ~HS_POL, ~VS_POL, 3'b000};
`else
    localparam int SW = 5;
    localparam logic [SW-1:0] RST_STAGE = {~HS_POL, ~VS_POL, 3'b000};
`endif

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] h_addr_q, h_addr_d;
    logic [CW-1:0] v_addr_q, v_addr_d;
    logic          h_sync_raw, v_sync_raw, h_act_raw, v_act_raw;
    logic          frame_raw, line_raw;
    logic [SW-1:0] stage_in;
    logic [SW-1:0] stage_out;
    logic [DLY-1:0][SW-1:0] pipe_q, pipe_d;
    logic [23:0]   colour_src;

    // Next counter state: h wraps at line end, v advances only on h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + CW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end
    end

    // Region decode and active-area addresses for the current counter state.
    always_comb begin
        h_sync_raw = (h_cnt_q < H_SYNC_E);
        v_sync_raw = (v_cnt_q < V_SYNC_E);
        h_act_raw  = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
        v_act_raw  = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
        frame_raw  = (h_cnt_q == H_ACT_S) && (v_cnt_q == V_ACT_S);
        line_raw   = (h_cnt_q == H_ACT_S) && v_act_raw;
        h_addr_d   = h_act_raw ? (h_cnt_q - H_ACT_S) : '0;
        v_addr_d   = v_act_raw ? (v_cnt_q - V_ACT_S) : '0;
    end

`ifdef VGA_CTRL_PARAM_TESTPAT_EN
    assign stage_in = {h_addr_d,
                       (h_sync_raw ? HS_POL : ~HS_POL),
                       (v_sync_raw ? VS_POL : ~VS_POL),
                       (h_act_raw && v_act_raw), frame_raw, line_raw};
`else
    assign stage_in = {(h_sync_raw ? HS_POL : ~HS_POL),
                       (v_sync_raw ? VS_POL : ~VS_POL),
                       (h_act_raw && v_act_raw), frame_raw, line_raw};
`endif

    if (DLY == 1) begin : g_pipe1
        assign pipe_d = stage_in;
    end else begin : g_pipen
        assign pipe_d = {pipe_q[DLY-2:0], stage_in};
    end

    // Counters, address registers and the timing delay line.
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_addr_q <= '0;
            v_addr_q <= '0;
            pipe_q   <= {DLY{RST_STAGE}};
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_addr_q <= h_addr_d;
            v_addr_q <= v_addr_d;
            pipe_q   <= pipe_d;
        end
    end

    assign stage_out   = pipe_q[DLY-1];
    assign h_addr      = h_addr_q;
    assign v_addr      = v_addr_q;
    assign hsync       = stage_out[4];
    assign vsync       = stage_out[3];
    assign valid       = stage_out[2];
    assign frame_start = stage_out[1];
    assign line_start  = stage_out[0];

`ifdef VGA_CTRL_PARAM_TESTPAT_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [CW-1:0] hpos_dly;
    logic [CW-1:0] bar_full;
    logic [2:0]    bar_idx;
    logic [23:0]   bar_colour;

    assign hpos_dly = stage_out[SW-1:5];

    // Bar colour from the delayed column; any remainder columns fall into the last (black) bar.
    always_comb begin
        bar_full = hpos_dly / CW'(BAR_W);
        bar_idx  = (bar_full > CW'(7)) ? 3'd7 : bar_full[2:0];
        case (bar_idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'h00FFFF;
            3'd2:    bar_colour = 24'hFFFF00;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'h0000FF;
            3'd6:    bar_colour = 24'hFF0000;
            default: bar_colour = 24'h000000;
        endcase
    end

    assign colour_src = test_en ? bar_colour : vga_data;
`else
    assign colour_src = vga_data;
`endif

    assign {vga_b, vga_g, vga_r} = valid ? colour_src : 24'h000000;

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Bench for vga_ctrl_param with a tiny 14x7 timing (H 2/2/8/2, V 1/1/4/1).
// A second instance with FETCH_LAT=0 checks the short-latency alignment.
module tb_vga_ctrl_param;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        test_en = 1'b0;
    logic        test_en0 = 1'b0;
    logic [23:0] vga_data;
    logic [23:0] vga_data0 = 24'h123456;

    logic [11:0] h_addr, v_addr, h_addr0, v_addr0;
    logic        hsync, vsync, valid, frame_start, line_start;
    logic        hsync0, vsync0, valid0, frame_start0, line_start0;
    logic [7:0]  vga_r, vga_g, vga_b, vga_r0, vga_g0, vga_b0;

    vga_ctrl_param #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12), .FETCH_LAT(2)
    ) dut (
        .pclk(pclk), .reset(reset),
`ifdef VGA_CTRL_PARAM_TESTPAT_EN
        .test_en(test_en),
`endif
        .vga_data(vga_data), .h_addr(h_addr), .v_addr(v_addr),
        .hsync(hsync), .vsync(vsync), .valid(valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .line_start(line_start)
    );

    vga_ctrl_param #(
        .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12), .FETCH_LAT(0)
    ) dut0 (
        .pclk(pclk), .reset(reset),
`ifdef VGA_CTRL_PARAM_TESTPAT_EN
        .test_en(test_en0),
`endif
        .vga_data(vga_data0), .h_addr(h_addr0), .v_addr(v_addr0),
        .hsync(hsync0), .vsync(vsync0), .valid(valid0),
        .vga_r(vga_r0), .vga_g(vga_g0), .vga_b(vga_b0),
        .frame_start(frame_start0), .line_start(line_start0)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [23:0] col;
        logic        fs;
        logic        ls;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   mon_en = 1'b0;
    int   ls_cnt = 0;
    int   fs_times[$];

    function automatic logic [23:0] ramp(logic [7:0] h, logic [7:0] v);
        return {8'hA0 + v, 8'h5A, 8'h10 + h};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-store model: returns ramp(address) two cycles after the address is presented.
    logic [15:0] fs1 = '0, fs2 = '0;
    always @(posedge pclk) begin
        cyc++;
        fs2 = fs1;
        fs1 = {v_addr[7:0], h_addr[7:0]};
    end
    assign vga_data = ramp(fs2[7:0], fs2[15:8]);

    // Scoreboard monitor: each valid pixel pops one expected entry; blanking must be all-zero.
    always @(negedge pclk) begin
        if (mon_en) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_extra: valid pixel with empty queue (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("pix_col", {8'h0, vga_b, vga_g, vga_r}, {8'h0, e.col});
                    chk("pix_fs", {31'h0, frame_start}, {31'h0, e.fs});
                    chk("pix_ls", {31'h0, line_start}, {31'h0, e.ls});
                end
            end else begin
                chk("blank_col", {8'h0, vga_b, vga_g, vga_r}, 32'h0);
                chk("blank_pulse", {30'h0, frame_start, line_start}, 32'h0);
            end
            if (line_start) ls_cnt++;
            if (frame_start) fs_times.push_back(cyc);
        end
    end

    // Counts cycles after reset release: sync/valid timing for both latencies, quiet pipeline.
    task automatic release_timing(string tag);
        int hs_k = -1;
        int v_k = -1;
        int v0_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge pclk);
            #1;
            if (k <= 3) chk({tag, "_quiet"}, {30'h0, valid, frame_start}, 32'h0);
            if (hs_k < 0 && hsync == 1'b0) hs_k = k;
            if (v_k < 0 && valid) v_k = k;
            if (v0_k < 0 && valid0) begin
                v0_k = k;
                chk({tag, "_lat0_col"}, {8'h0, vga_b0, vga_g0, vga_r0}, 32'h123456);
                chk({tag, "_lat0_fs"}, {31'h0, frame_start0}, 32'h1);
            end
        end
        chk({tag, "_first_hsync"}, hs_k, 3);
        chk({tag, "_first_valid"}, v_k, 35);
        chk({tag, "_first_valid_lat0"}, v0_k, 33);
    endtask

    int n;

`ifdef VGA_CTRL_PARAM_TESTPAT_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                              24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
`endif

    initial begin
        reset = 1'b1;
        repeat (3) begin
            @(posedge pclk);
            #1;
            chk("rst_hsync", {31'h0, hsync}, 32'h1);
            chk("rst_vsync", {31'h0, vsync}, 32'h1);
            chk("rst_valid", {31'h0, valid}, 32'h0);
        end

        // Expected pixels for two frames.
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < 4; v++)
                for (int h = 0; h < 8; h++)
                    sb.push_back('{col: ramp(8'(h), 8'(v)), fs: (h == 0 && v == 0), ls: (h == 0)});

        mon_en = 1'b1;
        @(negedge pclk);
        reset = 1'b0;
        release_timing("rel");

        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge pclk);
            n++;
        end
        mon_en = 1'b0;
        chk("sb_drained", sb.size(), 0);
        chk("ls_count", ls_cnt, 8);
        chk("fs_count", fs_times.size(), 2);
        if (fs_times.size() == 2) chk("frame_period", fs_times[1] - fs_times[0], 98);

        // Mid-frame reset at counter state h=6, v=3 (13 cycles after frame_start is seen).
        n = 0;
        do begin
            @(posedge pclk);
            #1;
            n++;
        end while (!frame_start && n < 200);
        chk("fs_before_midreset", {31'h0, frame_start}, 32'h1);
        repeat (13) @(posedge pclk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("mid_rst_valid", {31'h0, valid}, 32'h0);
        chk("mid_rst_hsync", {31'h0, hsync}, 32'h1);
        reset = 1'b0;
        release_timing("mid");

`ifdef VGA_CTRL_PARAM_TESTPAT_EN
        test_en = 1'b1;
        n = 0;
        do begin
            @(posedge pclk);
            #1;
            n++;
        end while (!line_start && n < 200);
        chk("tp_line_start", {31'h0, line_start}, 32'h1);
        for (int c = 0; c < 8; c++) begin
            chk("tp_valid", {31'h0, valid}, 32'h1);
            chk("tp_bar", {8'h0, vga_b, vga_g, vga_r}, {8'h0, bars[c]});
            @(posedge pclk);
            #1;
        end
        test_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
